// File: rtl/lock_seq_pkg.sv
// Shared definitions for the cascaded-servo lock sequencer.
// Holds the FSM state encoding, the BACKOFF dwell length and the retry-counter width.
package lock_seq_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAcquire = 3'd1,
    StSettle  = 3'd2,
    StLocked  = 3'd3,
    StBackoff = 3'd4,
    StFault   = 3'd5
  } state_e;

  localparam int unsigned BACKOFF_CYCLES = 16;
  localparam int unsigned RETRY_W        = 4;

endpackage

// File: rtl/lock_timer.sv
// Clearable, saturating up-counter with a terminal-count compare.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset
//   clr   - clear the count (wins over counting)
//   limit - terminal count
//   hit   - the count after this cycle's increment has reached limit
// The counter advances every cycle it is not cleared, so hit is a look-ahead:
// it tells the owner that the edge about to occur completes the interval.
module lock_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         hit
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_inc;

  assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;
  // >= so a limit lowered mid-interval still terminates at the next compare.
  assign hit       = (count_inc >= limit);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_inc;
    end
  end

endmodule

// File: rtl/lock_sequencer.sv
// Lock sequencer for a cascade of auto-lock servos (index 0 innermost).
// Brings servos up one stage at a time, requiring a stage's pid_on to stay
// high for a hold interval before moving outward, with per-attempt timeout,
// retry/backoff and fault handling.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - arms the sequence (rising edge) from IDLE or FAULT
//   stop_all        - forces IDLE
//   pid_on          - PIDon from each auto-lock
//   hold_cycles     - hold interval (0 treated as 1)
//   timeout_cycles  - per-attempt timeout (0 disables)
//   max_retries     - timeouts tolerated before FAULT
//   stop_servo, primary_mode, primary_locked - per-servo controls
//   stage, state, all_locked, fault, retry_cnt - status
module lock_sequencer
  import lock_seq_pkg::*;
#(
  parameter int unsigned N_SERVO = 3,
  parameter int unsigned HOLD_W  = 24,
  parameter int unsigned TMO_W   = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop_all,
  input  logic [N_SERVO-1:0]  pid_on,
  input  logic [HOLD_W-1:0]   hold_cycles,
  input  logic [TMO_W-1:0]    timeout_cycles,
  input  logic [3:0]          max_retries,
  output logic [N_SERVO-1:0]  stop_servo,
  output logic [N_SERVO-1:0]  primary_mode,
  output logic [N_SERVO-1:0]  primary_locked,
  output logic [2:0]          stage,
  output logic [2:0]          state,
  output logic                all_locked,
  output logic                fault,
  output logic [RETRY_W-1:0]  retry_cnt
);

  localparam int unsigned BoW = $clog2(BACKOFF_CYCLES);

  state_e             state_q, state_d;
  logic [2:0]         stage_q, stage_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic [BoW-1:0]     bo_q, bo_d;
  logic               start_q, arm;
  logic [7:0]         pid_pad;
  logic               pid_k;
  logic               lost;
  logic [2:0]         lost_idx;
  logic [HOLD_W-1:0]  hold_limit;
  logic               hold_hit, hold_clr;
  logic               tmo_hit_raw, tmo_hit, tmo_keep;
  logic               active_d;
  logic [N_SERVO-1:0] stop_d, locked_d;

  assign arm        = start && !start_q;
  assign pid_pad    = 8'(pid_on);
  assign pid_k      = pid_pad[stage_q];
  assign retry_inc  = (retry_q == '1) ? retry_q : retry_q + 1'b1;
  assign hold_limit = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
  assign tmo_hit    = (timeout_cycles != '0) && tmo_hit_raw;
  // Hold interval restarts on every entry into SETTLE.
  assign hold_clr   = !((state_q == StSettle) && (state_d == StSettle));

  lock_timer #(.W(HOLD_W)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .clr   (hold_clr),
    .limit (hold_limit),
    .hit   (hold_hit)
  );

  lock_timer #(.W(TMO_W)) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .clr   (!tmo_keep),
    .limit (timeout_cycles),
    .hit   (tmo_hit_raw)
  );

  // Lowest dropped servo below the current stage (at or below it once LOCKED).
  always_comb begin
    lost     = 1'b0;
    lost_idx = '0;
    for (int j = int'(N_SERVO) - 1; j >= 0; j--) begin
      if (!pid_on[j] && ((j < int'(stage_q)) ||
                         ((state_q == StLocked) && (j == int'(stage_q))))) begin
        lost     = 1'b1;
        lost_idx = 3'(j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    retry_d  = retry_q;
    bo_d     = '0;
    tmo_keep = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arm) begin
          state_d = StAcquire;
          stage_d = '0;
        end
      end
      StFault: begin
        if (arm) begin
          state_d = StAcquire;
          stage_d = '0;
          retry_d = '0;
        end
      end
      StBackoff: begin
        if (bo_q == BoW'(BACKOFF_CYCLES - 1)) begin
          state_d = StAcquire;
          stage_d = '0;
        end else begin
          bo_d = bo_q + 1'b1;
        end
      end
      StAcquire, StSettle, StLocked: begin
        if (lost) begin
          state_d = StAcquire;
          stage_d = lost_idx;
        end else if ((state_q != StLocked) && tmo_hit) begin
          retry_d = retry_inc;
          stage_d = '0;
          state_d = (retry_inc > max_retries) ? StFault : StBackoff;
        end else if (state_q == StAcquire) begin
          tmo_keep = 1'b1;
          if (pid_k) state_d = StSettle;
        end else if (state_q == StSettle) begin
          tmo_keep = 1'b1;
          if (!pid_k) begin
            state_d = StAcquire;
          end else if (hold_hit) begin
            tmo_keep = 1'b0;
            if (stage_q == 3'(N_SERVO - 1)) begin
              state_d = StLocked;
            end else begin
              state_d = StAcquire;
              stage_d = stage_q + 3'd1;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
        stage_d = '0;
        retry_d = '0;
      end
    endcase
    if (stop_all) begin
      state_d  = StIdle;
      stage_d  = '0;
      retry_d  = '0;
      bo_d     = '0;
      tmo_keep = 1'b0;
    end
  end

  // Servo controls decoded from next state so they register alongside it.
  always_comb begin
    active_d    = (state_d == StAcquire) || (state_d == StSettle) || (state_d == StLocked);
    stop_d      = '1;
    locked_d    = '0;
    locked_d[0] = active_d;
    for (int i = 0; i < int'(N_SERVO); i++) begin
      stop_d[i] = active_d ? (i > int'(stage_d)) : 1'b1;
    end
    for (int i = 1; i < int'(N_SERVO); i++) begin
      locked_d[i] = active_d && pid_on[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      stage_q        <= '0;
      retry_q        <= '0;
      bo_q           <= '0;
      start_q        <= 1'b0;
      stop_servo     <= '1;
      primary_mode   <= '1;
      primary_locked <= '0;
      all_locked     <= 1'b0;
      fault          <= 1'b0;
    end else begin
      state_q        <= state_d;
      stage_q        <= stage_d;
      retry_q        <= retry_d;
      bo_q           <= bo_d;
      start_q        <= start;
      stop_servo     <= stop_d;
      primary_mode   <= stop_d;
      primary_locked <= locked_d;
      all_locked     <= (state_d == StLocked);
      fault          <= (state_d == StFault);
    end
  end

  assign state     = state_q;
  assign stage     = stage_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_lock_sequencer.sv
module tb_lock_sequencer;
  import lock_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop_all;
  logic [2:0]  pid_on;
  logic [23:0] hold_cycles;
  logic [27:0] timeout_cycles;
  logic [3:0]  max_retries;
  logic [2:0]  stop_servo, primary_mode, primary_locked, stage, state;
  logic        all_locked, fault;
  logic [3:0]  retry_cnt;

  int tests = 0;
  int fails = 0;

  lock_sequencer #(.N_SERVO(3), .HOLD_W(24), .TMO_W(28)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stop_all       (stop_all),
    .pid_on         (pid_on),
    .hold_cycles    (hold_cycles),
    .timeout_cycles (timeout_cycles),
    .max_retries    (max_retries),
    .stop_servo     (stop_servo),
    .primary_mode   (primary_mode),
    .primary_locked (primary_locked),
    .stage          (stage),
    .state          (state),
    .all_locked     (all_locked),
    .fault          (fault),
    .retry_cnt      (retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       start;
    logic       stop_all;
    logic [2:0] pid;
    logic [2:0] st;
    logic [2:0] stg;
    logic [2:0] stop;
    logic [2:0] pm;
    logic [2:0] pl;
    logic       al;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic sa, input logic [2:0] p, input state_e st,
                     input logic [2:0] stg, input logic [2:0] stop, input logic [2:0] pl,
                     input logic al);
    vec_t v;
    v.start = s; v.stop_all = sa; v.pid = p; v.st = st; v.stg = stg;
    v.stop = stop; v.pm = stop; v.pl = pl; v.al = al;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input state_e target, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((state !== target) && (n < budget));
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; stop_all = 1'b0; pid_on = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; start = 1'b0; stop_all = 1'b0; pid_on = '0;
    hold_cycles = 24'd4; timeout_cycles = '0; max_retries = 4'd3;
    tick(); tick();
    // Reset values
    chk("reset_outputs", {state, stage, stop_servo, primary_mode, primary_locked,
                          all_locked, fault, retry_cnt},
        {3'(StIdle), 3'd0, 3'b111, 3'b111, 3'b000, 1'b0, 1'b0, 4'd0});
    rst = 1'b0;

    // Stage-by-stage lock, loss of a lower stage, stop_all, start re-arm once
    add(0, 0, 3'b000, StIdle,    0, 3'b111, 3'b000, 0);
    add(1, 0, 3'b000, StAcquire, 0, 3'b110, 3'b001, 0);
    add(0, 0, 3'b001, StSettle,  0, 3'b110, 3'b011, 0);
    add(0, 0, 3'b001, StSettle,  0, 3'b110, 3'b011, 0);
    add(0, 0, 3'b001, StSettle,  0, 3'b110, 3'b011, 0);
    add(0, 0, 3'b001, StSettle,  0, 3'b110, 3'b011, 0);
    add(0, 0, 3'b001, StAcquire, 1, 3'b100, 3'b011, 0);
    add(0, 0, 3'b011, StSettle,  1, 3'b100, 3'b111, 0);
    add(0, 0, 3'b011, StSettle,  1, 3'b100, 3'b111, 0);
    add(0, 0, 3'b011, StSettle,  1, 3'b100, 3'b111, 0);
    add(0, 0, 3'b011, StSettle,  1, 3'b100, 3'b111, 0);
    add(0, 0, 3'b011, StAcquire, 2, 3'b000, 3'b111, 0);
    add(0, 0, 3'b111, StSettle,  2, 3'b000, 3'b111, 0);
    add(0, 0, 3'b111, StSettle,  2, 3'b000, 3'b111, 0);
    add(0, 0, 3'b111, StSettle,  2, 3'b000, 3'b111, 0);
    add(0, 0, 3'b111, StSettle,  2, 3'b000, 3'b111, 0);
    add(0, 0, 3'b111, StLocked,  2, 3'b000, 3'b111, 1);
    add(0, 0, 3'b111, StLocked,  2, 3'b000, 3'b111, 1);
    add(0, 0, 3'b101, StAcquire, 1, 3'b100, 3'b011, 0);
    add(0, 0, 3'b111, StSettle,  1, 3'b100, 3'b111, 0);
    add(0, 1, 3'b111, StIdle,    0, 3'b111, 3'b000, 0);
    add(1, 0, 3'b111, StAcquire, 0, 3'b110, 3'b111, 0);
    add(1, 1, 3'b111, StIdle,    0, 3'b111, 3'b000, 0);
    add(1, 0, 3'b111, StIdle,    0, 3'b111, 3'b000, 0);
    add(0, 0, 3'b111, StIdle,    0, 3'b111, 3'b000, 0);
    add(1, 0, 3'b001, StAcquire, 0, 3'b110, 3'b011, 0);
    add(0, 0, 3'b001, StSettle,  0, 3'b110, 3'b011, 0);

    foreach (vecs[i]) begin
      start = vecs[i].start; stop_all = vecs[i].stop_all; pid_on = vecs[i].pid;
      tick();
      chk($sformatf("vec%0d", i),
          {state, stage, stop_servo, primary_mode, primary_locked, all_locked, fault, retry_cnt},
          {vecs[i].st, vecs[i].stg, vecs[i].stop, vecs[i].pm, vecs[i].pl, vecs[i].al,
           1'b0, 4'd0});
    end

    // Timeout, two backoffs, then fault; start re-arms and clears retries
    timeout_cycles = 28'd100; max_retries = 4'd2; hold_cycles = 24'd4;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    chk("tmo_armed", state, 3'(StAcquire));
    wait_state(StBackoff, 300, n);
    chk("tmo1_cycles", n, 100);
    chk("tmo1_retry", {state, retry_cnt, stop_servo, primary_locked}, {3'(StBackoff), 4'd1, 3'b111, 3'b000});
    wait_state(StAcquire, 100, n);
    chk("backoff1_cycles", n, BACKOFF_CYCLES);
    wait_state(StBackoff, 300, n);
    chk("tmo2_cycles", n, 100);
    chk("tmo2_retry", retry_cnt, 4'd2);
    wait_state(StAcquire, 100, n);
    wait_state(StFault, 300, n);
    chk("tmo3_cycles", n, 100);
    chk("fault_outputs", {state, fault, retry_cnt, stage, stop_servo, primary_mode, all_locked},
        {3'(StFault), 1'b1, 4'd3, 3'd0, 3'b111, 3'b111, 1'b0});
    tick();
    chk("fault_hold", {state, retry_cnt}, {3'(StFault), 4'd3});
    start = 1'b1; tick(); start = 1'b0;
    chk("fault_rearm", {state, fault, retry_cnt}, {3'(StAcquire), 1'b0, 4'd0});

    // stop_all beats start and a coincident timeout
    timeout_cycles = 28'd5; max_retries = 4'd3;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    wait_state(StBackoff, 50, n);
    chk("short_tmo_cycles", {n[7:0], retry_cnt}, {8'd5, 4'd1});
    wait_state(StAcquire, 50, n);
    repeat (4) tick();
    chk("pre_coincide", state, 3'(StAcquire));
    stop_all = 1'b1; start = 1'b1; tick(); stop_all = 1'b0; start = 1'b0;
    chk("stop_all_prio", {state, retry_cnt, stop_servo}, {3'(StIdle), 4'd0, 3'b111});

    // Reset in SETTLE at stage 2
    timeout_cycles = '0; hold_cycles = 24'd4;
    do_reset();
    pid_on = 3'b111;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!((state == 3'(StSettle)) && (stage == 3'd2)) && (n < 40)) begin
      tick();
      n++;
    end
    chk("reach_settle2", {state, stage}, {3'(StSettle), 3'd2});
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_seq", {state, stage, stop_servo, primary_mode, primary_locked,
                        all_locked, fault, retry_cnt},
        {3'(StIdle), 3'd0, 3'b111, 3'b111, 3'b000, 1'b0, 1'b0, 4'd0});

    // hold_cycles = 0 behaves as a single-cycle hold
    hold_cycles = '0;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    pid_on = 3'b001; tick();
    chk("h0_settle0", {state, stage}, {3'(StSettle), 3'd0});
    tick();
    chk("h0_acq1", {state, stage, stop_servo}, {3'(StAcquire), 3'd1, 3'b100});
    pid_on = 3'b011; tick(); tick();
    chk("h0_acq2", {state, stage}, {3'(StAcquire), 3'd2});
    pid_on = 3'b111; tick(); tick();
    chk("h0_locked", {state, all_locked}, {3'(StLocked), 1'b1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 Parameter N_SERVO, default 3, number of cascaded servos (2..8); index 0 is the innermost/primary servo.
REQ-002 Parameter HOLD_W, default 24, width of the lock-hold counter.
REQ-003 Parameter TMO_W, default 28, width of the acquisition-timeout counter.
REQ-004 clk  in  1  sole clock; all logic on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level; arms the lock sequence from IDLE or FAULT.
REQ-007 stop_all  in  1  level; forces IDLE and stops every servo.
REQ-008 pid_on  in  N_SERVO  PIDon outputs of the auto-lock instances.
REQ-009 hold_cycles  in  HOLD_W  consecutive pid_on cycles required to declare a stage locked.
REQ-010 timeout_cycles  in  TMO_W  acquisition timeout per attempt; 0 disables the timeout.
REQ-011 max_retries  in  4  timeouts tolerated before FAULT.
REQ-012 stop_servo  out  N_SERVO  drives each auto-lock's STOPthisServo.
REQ-013 primary_mode  out  N_SERVO  drives each auto-lock's primary_servo_mode.
REQ-014 primary_locked  out  N_SERVO  drives each auto-lock's primary_servo_locked.
REQ-015 stage  out  3  index k of the servo currently being acquired.
REQ-016 state  out  3  FSM state encoding.
REQ-017 all_locked, fault  out  1 each  status flags.
REQ-018 retry_cnt  out  4  timeouts since the last start.

Function
REQ-019 States: IDLE, ACQUIRE, SETTLE, LOCKED, BACKOFF, FAULT; all outputs registered; pid_on sampled at edge n produces its state/output change at edge n+1.
REQ-020 Priority: rst > stop_all > lower-stage loss > timeout > progress.
REQ-021 IDLE: stop_servo all 1, primary_mode all 1, primary_locked all 0, stage 0, retry_cnt 0; on start go to ACQUIRE with k=0 and the timers cleared.
REQ-022 In ACQUIRE, SETTLE and LOCKED: stop_servo[i]=0 for i<=k and 1 for i>k.
REQ-023 In ACQUIRE, SETTLE and LOCKED: primary_mode[i]=1 for i>k and 0 otherwise.
REQ-024 primary_locked[0]=1 when not in IDLE, BACKOFF or FAULT; primary_locked[i]=pid_on[i-1] registered for i>0.
REQ-025 ACQUIRE: the timeout counter increments each cycle; pid_on[k]=1 moves to SETTLE with the hold counter cleared.
REQ-026 SETTLE: the hold counter increments while pid_on[k]=1; pid_on[k]=0 returns to ACQUIRE with stage k unchanged and the timeout counter retained.
REQ-027 SETTLE completion: when the hold count reaches max(hold_cycles,1), go to LOCKED if k=N_SERVO-1, else to ACQUIRE with k+1 and both counters cleared.
REQ-028 Timeout: in ACQUIRE or SETTLE, when timeout_cycles!=0 and the timeout count reaches timeout_cycles, increment retry_cnt.
REQ-029 On that timeout, go to FAULT if the incremented retry_cnt exceeds max_retries, else to BACKOFF.
REQ-030 BACKOFF: all outputs as in IDLE except retry_cnt, for BACKOFF_CYCLES; then ACQUIRE with k=0.
REQ-031 Lower-stage loss: in ACQUIRE, SETTLE or LOCKED, if pid_on[j]=0 for any j<k (any j<=k in LOCKED), go to ACQUIRE with k=lowest such j and the timers cleared; retry_cnt is unchanged.
REQ-032 LOCKED: all_locked=1; all_locked=0 in every other state.
REQ-033 FAULT: fault=1, with outputs as in IDLE except retry_cnt held; start re-enters ACQUIRE with k=0 and retry_cnt cleared; start held high in IDLE or FAULT re-arms only once.
REQ-034 Counters saturate and never wrap; hold_cycles and timeout_cycles are sampled continuously, and a mid-attempt change takes effect at the next compare.

Reset
REQ-035 rst asserted at any edge forces IDLE at that edge, including mid-sequence.
REQ-036 Reset values are the IDLE output values; fault=0, all_locked=0, both counters 0.

Structure
REQ-037 Package lock_seq_pkg holds the state enumeration, BACKOFF_CYCLES=16 and the retry-counter width.
REQ-038 One sub-module, lock_timer: a clearable, saturating up-counter with a terminal-count compare, instantiated for hold and timeout.

Verification
REQ-039 N=3, hold=4, timeout=0, pid_on rises stage by stage -> stage steps 0,1,2, stop_servo 110->100->000, all_locked 4 cycles after pid_on[2] settles.
REQ-040 In LOCKED, pid_on[1] pulses low for 1 cycle -> next cycle ACQUIRE, stage=1, stop_servo[2]=1, retry_cnt unchanged.
REQ-041 timeout=100, max_retries=2, pid_on all 0 -> BACKOFF twice (retry_cnt 1,2), FAULT after the third timeout at retry_cnt=3.
REQ-042 stop_all together with start and a timeout in the same cycle -> IDLE, retry_cnt 0.
REQ-043 rst asserted in SETTLE at stage 2 -> next edge IDLE, all outputs at reset values.
REQ-044 hold_cycles=0 -> each stage settles after 1 cycle of pid_on.
